// File: rtl/lstm_pkg.sv
// Shared types and sign-magnitude arithmetic helpers for the LSTM sequencer.
// Helpers work on generously wide vectors with the real widths passed as
// arguments, so one function serves every parameterisation; callers slice
// the part they need.
package lstm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_MAC   = 3'd3,
        ST_OUT   = 3'd4
    } lstm_state_t;

    localparam int SM_MAX = 64;   // widest sign-magnitude word supported
    localparam int TC_MAX = 128;  // wide enough for a full magnitude product

    // Mask covering the low 'bits' bits.
    function automatic logic [TC_MAX-1:0] mag_mask(input int bits);
        logic [TC_MAX-1:0] one;
        one = TC_MAX'(1);
        return (one << bits) - one;
    endfunction

    // Sign-magnitude (dw bits) to two's complement; -0 maps to 0.
    function automatic logic [TC_MAX-1:0] sm_to_tc(input logic [SM_MAX-1:0] v,
                                                   input int dw);
        logic [TC_MAX-1:0] mag;
        mag = {{(TC_MAX-SM_MAX){1'b0}}, v} & mag_mask(dw-1);
        if (v[dw-1] && (mag != '0))
            return ~mag + TC_MAX'(1);
        return mag;
    endfunction

    // Fixed-point multiply of two sign-magnitude words. The product magnitude
    // is truncated by frac bits and clamped to the positive range of an
    // aw-bit accumulator so a single huge term cannot wrap the sum.
    function automatic logic [TC_MAX-1:0] sm_mul(input logic [SM_MAX-1:0] a,
                                                 input logic [SM_MAX-1:0] b,
                                                 input int dw,
                                                 input int frac,
                                                 input int aw);
        logic [TC_MAX-1:0] ma;
        logic [TC_MAX-1:0] mb;
        logic [TC_MAX-1:0] prod;
        logic [TC_MAX-1:0] lim;
        ma   = {{(TC_MAX-SM_MAX){1'b0}}, a} & mag_mask(dw-1);
        mb   = {{(TC_MAX-SM_MAX){1'b0}}, b} & mag_mask(dw-1);
        prod = (ma * mb) >> frac;
        lim  = mag_mask(aw-1);
        if (prod > lim)
            prod = lim;
        if ((a[dw-1] ^ b[dw-1]) && (prod != '0))
            return ~prod + TC_MAX'(1);
        return prod;
    endfunction

    // Two's complement back to dw-bit sign-magnitude with magnitude clamp.
    // Zero always comes out with a clear sign bit.
    function automatic logic [SM_MAX-1:0] tc_to_sm_sat(input  logic [TC_MAX-1:0] v,
                                                       input  int dw,
                                                       output logic sat);
        logic              neg;
        logic [TC_MAX-1:0] mag;
        logic [TC_MAX-1:0] lim;
        logic [SM_MAX-1:0] res;
        neg = v[TC_MAX-1];
        mag = neg ? (~v + TC_MAX'(1)) : v;
        lim = mag_mask(dw-1);
        sat = (mag > lim);
        if (sat)
            mag = lim;
        res = mag[SM_MAX-1:0];
        if (neg && (mag != '0))
            res[dw-1] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Fully-connected accumulator: bias load, one saturating add per step, and
// the unit index that selects which h/w pair feeds the next term.
module fc_mac
    import lstm_pkg::*;
#(
    parameter int UNITS     = 4,
    parameter int ACC_WIDTH = 40,
    localparam int IW       = (UNITS > 1) ? $clog2(UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_bias,
    input  logic [ACC_WIDTH-1:0] bias,
    input  logic                 step,
    input  logic [ACC_WIDTH-1:0] term,
    output logic [IW-1:0]        idx,
    output logic [ACC_WIDTH-1:0] acc_sum,
    output logic                 done
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   raw_sum;
    logic                 last;

    // Saturating add of the current term; exposed so the final sum can be
    // converted in the same cycle it is formed.
    always_comb begin
        raw_sum = {acc[ACC_WIDTH-1], acc} + {term[ACC_WIDTH-1], term};
        acc_sum = raw_sum[ACC_WIDTH-1:0];
        if (raw_sum[ACC_WIDTH] != raw_sum[ACC_WIDTH-1])
            acc_sum = raw_sum[ACC_WIDTH] ? ACC_MAX_NEG : ACC_MAX_POS;
    end

    assign last = (idx == IW'(UNITS-1));
    assign done = step && last;

    // Accumulator and unit index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            idx <= '0;
        end else if (load_bias) begin
            acc <= bias;
            idx <= '0;
        end else if (step) begin
            acc <= acc_sum;
            idx <= last ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/lstm_seq_head.sv
// Sequencer for the LSTM inference path: feeds SEQ_LEN samples through an
// external cell, keeps h/c between steps, then runs the FC output layer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for the next sample; clears h/c when a new sequence starts
// ST_START | one-cycle cell_start pulse
// ST_WAIT  | waiting for cell_done; latch h/c, bump step
// ST_MAC   | one h[i]*w_fc[i] term per cycle on top of the bias
// ST_OUT   | holding the prediction until pred_ready
module lstm_seq_head
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int UNITS      = 4,
    parameter int SEQ_LEN    = 2,
    parameter int ACC_WIDTH  = 40,
    localparam int AW        = $clog2(UNITS+1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [DATA_WIDTH-1:0]       x_data,
    output logic                        cell_start,
    output logic [DATA_WIDTH-1:0]       cell_x,
    output logic [UNITS*DATA_WIDTH-1:0] cell_h_prev,
    output logic [UNITS*DATA_WIDTH-1:0] cell_c_prev,
    input  logic                        cell_done,
    input  logic [UNITS*DATA_WIDTH-1:0] cell_h,
    input  logic [UNITS*DATA_WIDTH-1:0] cell_c,
    input  logic                        w_wr_en,
    input  logic [AW-1:0]               w_wr_addr,
    input  logic [DATA_WIDTH-1:0]       w_wr_data,
    output logic                        pred_valid,
    input  logic                        pred_ready,
    output logic [DATA_WIDTH-1:0]       pred,
    output logic                        pred_sat,
    output logic                        busy
);

    localparam int IW = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam int SW = $clog2(SEQ_LEN+1);

    lstm_state_t                 state;
    logic [SW-1:0]               step;
    logic [SW-1:0]               step_inc;
    logic                        seq_last;
    logic [UNITS*DATA_WIDTH-1:0] h_reg;
    logic [UNITS*DATA_WIDTH-1:0] c_reg;
    logic [DATA_WIDTH-1:0]       w_fc [UNITS];
    logic [DATA_WIDTH-1:0]       b_fc;
    logic [DATA_WIDTH-1:0]       x_norm;

    logic                        mac_load;
    logic                        mac_step;
    logic                        mac_done;
    logic [IW-1:0]               mac_idx;
    logic [ACC_WIDTH-1:0]        acc_sum;
    logic [TC_MAX-1:0]           bias_wide;
    logic [TC_MAX-1:0]           term_wide;
    logic [SM_MAX-1:0]           pred_wide;
    logic                        pred_sat_c;
    logic                        unused_hi_bits;

    assign busy        = (state != ST_IDLE) || (step != '0);
    assign cell_h_prev = h_reg;
    assign cell_c_prev = c_reg;
    assign step_inc    = step + SW'(1);
    assign seq_last    = (step_inc == SW'(SEQ_LEN));
    assign x_norm      = (x_data[DATA_WIDTH-2:0] == '0) ? '0 : x_data;
    assign mac_load    = (state == ST_WAIT) && cell_done && seq_last;
    assign mac_step    = (state == ST_MAC);

    // Arithmetic glue between the sign-magnitude registers and the accumulator.
    always_comb begin
        bias_wide = sm_to_tc({{(SM_MAX-DATA_WIDTH){1'b0}}, b_fc}, DATA_WIDTH);
        term_wide = sm_mul({{(SM_MAX-DATA_WIDTH){1'b0}}, h_reg[mac_idx*DATA_WIDTH +: DATA_WIDTH]},
                           {{(SM_MAX-DATA_WIDTH){1'b0}}, w_fc[mac_idx]},
                           DATA_WIDTH, FRAC_BITS, ACC_WIDTH);
        pred_sat_c = 1'b0;
        pred_wide  = tc_to_sm_sat({{(TC_MAX-ACC_WIDTH){acc_sum[ACC_WIDTH-1]}}, acc_sum},
                                  DATA_WIDTH, pred_sat_c);
    end

    assign unused_hi_bits = ^{bias_wide[TC_MAX-1:ACC_WIDTH],
                              term_wide[TC_MAX-1:ACC_WIDTH],
                              pred_wide[SM_MAX-1:DATA_WIDTH]};

    fc_mac #(
        .UNITS     (UNITS),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_fc_mac (
        .clk       (clk),
        .rst       (rst),
        .load_bias (mac_load),
        .bias      (bias_wide[ACC_WIDTH-1:0]),
        .step      (mac_step),
        .term      (term_wide[ACC_WIDTH-1:0]),
        .idx       (mac_idx),
        .acc_sum   (acc_sum),
        .done      (mac_done)
    );

    // FC weight file; writes land only while no sequence is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < UNITS; i++)
                w_fc[i] <= '0;
            b_fc <= '0;
        end else if (w_wr_en && !busy) begin
            if (w_wr_addr < AW'(UNITS))
                w_fc[w_wr_addr[IW-1:0]] <= w_wr_data;
            else if (w_wr_addr == AW'(UNITS))
                b_fc <= w_wr_data;
        end
    end

    // Sequencing FSM with registered outputs and h/c state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step       <= '0;
            x_ready    <= 1'b0;
            cell_start <= 1'b0;
            cell_x     <= '0;
            h_reg      <= '0;
            c_reg      <= '0;
            pred_valid <= 1'b0;
            pred       <= '0;
            pred_sat   <= 1'b0;
        end else begin
            cell_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (x_valid && x_ready) begin
                        cell_x <= x_norm;
                        if (step == '0) begin
                            h_reg <= '0;
                            c_reg <= '0;
                        end
                        x_ready    <= 1'b0;
                        cell_start <= 1'b1;
                        state      <= ST_START;
                    end else begin
                        x_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cell_done) begin
                        h_reg <= cell_h;
                        c_reg <= cell_c;
                        step  <= step_inc;
                        if (seq_last) begin
                            state <= ST_MAC;
                        end else begin
                            state   <= ST_IDLE;
                            x_ready <= 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (mac_done) begin
                        pred       <= pred_wide[DATA_WIDTH-1:0];
                        pred_sat   <= pred_sat_c;
                        pred_valid <= 1'b1;
                        state      <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (pred_ready) begin
                        pred_valid <= 1'b0;
                        pred       <= '0;
                        pred_sat   <= 1'b0;
                        step       <= '0;
                        x_ready    <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_seq_head.sv
// Directed bench for lstm_seq_head with a fixed-latency cell model.
module tb_lstm_seq_head;

    localparam int DW    = 32;
    localparam int UNITS = 4;
    localparam int AW    = $clog2(UNITS+1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  x_valid = 1'b0;
    logic                  x_ready;
    logic [DW-1:0]         x_data = '0;
    logic                  cell_start;
    logic [DW-1:0]         cell_x;
    logic [UNITS*DW-1:0]   cell_h_prev;
    logic [UNITS*DW-1:0]   cell_c_prev;
    logic                  cell_done = 1'b0;
    logic [UNITS*DW-1:0]   cell_h = '0;
    logic [UNITS*DW-1:0]   cell_c = '0;
    logic                  w_wr_en = 1'b0;
    logic [AW-1:0]         w_wr_addr = '0;
    logic [DW-1:0]         w_wr_data = '0;
    logic                  pred_valid;
    logic                  pred_ready = 1'b0;
    logic [DW-1:0]         pred;
    logic                  pred_sat;
    logic                  busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nstarts  = 0;
    int cnt      = 0;
    int done_cyc = 0;

    logic [DW-1:0]       got_pred;
    logic                got_sat;
    logic [UNITS*DW-1:0] hprev0, hprev1, cprev1;
    logic [DW-1:0]       cx0;

    lstm_seq_head dut (
        .clk         (clk),
        .rst         (rst),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .cell_start  (cell_start),
        .cell_x      (cell_x),
        .cell_h_prev (cell_h_prev),
        .cell_c_prev (cell_c_prev),
        .cell_done   (cell_done),
        .cell_h      (cell_h),
        .cell_c      (cell_c),
        .w_wr_en     (w_wr_en),
        .w_wr_addr   (w_wr_addr),
        .w_wr_data   (w_wr_data),
        .pred_valid  (pred_valid),
        .pred_ready  (pred_ready),
        .pred        (pred),
        .pred_sat    (pred_sat),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Cell model: result three negedges after the start pulse is seen.
    always @(negedge clk) begin
        cell_done = 1'b0;
        if (cell_start) begin
            nstarts++;
            cnt = 3;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                cell_done = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_w(input int addr, input logic [DW-1:0] data);
        w_wr_en   = 1'b1;
        w_wr_addr = AW'(addr);
        w_wr_data = data;
        @(posedge clk);
        @(negedge clk);
        w_wr_en = 1'b0;
    endtask

    task automatic load_weights(input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int i = 0; i < UNITS; i++) write_w(i, w);
        write_w(UNITS, b);
    endtask

    task automatic set_cell(input logic [DW-1:0] h, input logic [DW-1:0] c);
        cell_h = {UNITS{h}};
        cell_c = {UNITS{c}};
    endtask

    task automatic send_sample(input logic [DW-1:0] x);
        int n = 0;
        while (!x_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) check_eq("x_ready_timeout", x_ready, 1);
        x_valid = 1'b1;
        x_data  = x;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic run_seq(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                           input bit mid_en, input logic [DW-1:0] mid_data,
                           input int hold);
        int st0 = nstarts;
        int n   = 0;
        int pv_cyc;
        send_sample(x0);
        check_eq("start_t1", cell_start, 1);
        hprev0 = cell_h_prev;
        cx0    = cell_x;
        if (mid_en) begin
            check_eq("busy_mid", busy, 1);
            write_w(1, mid_data);
        end
        send_sample(x1);
        hprev1 = cell_h_prev;
        cprev1 = cell_c_prev;
        while (!pred_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("pred_valid_seen", pred_valid, 1);
        pv_cyc = cyc;
        check_eq("pv_latency", pv_cyc, done_cyc + 1 + UNITS);
        got_pred = pred;
        got_sat  = pred_sat;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_pred", pred, got_pred);
            check_eq("hold_valid", pred_valid, 1);
            check_eq("hold_x_ready", x_ready, 0);
        end
        pred_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pred_ready = 1'b0;
        check_eq("x_ready_after_pred", x_ready, 1);
        check_eq("pred_valid_dropped", pred_valid, 0);
        check_eq("start_count", nstarts - st0, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_x_ready", x_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pred_valid", pred_valid, 0);
        check_eq("rst_pred", pred, 0);
        check_eq("rst_cell_start", cell_start, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("x_ready_post_rst", x_ready, 1);

        // basic
        load_weights(32'h0001_0000, 32'h0000_8000);
        set_cell(32'h0000_4000, 32'h0000_1234);
        run_seq(32'h0001_0000, 32'h0002_0000, 0, 0, 0);
        check_eq("basic_pred", got_pred, 32'h0001_8000);
        check_eq("basic_sat", got_sat, 0);
        check_eq("basic_cx0", cx0, 32'h0001_0000);
        check_eq("basic_hprev0", hprev0, 0);
        check_eq("basic_hprev1", hprev1, {UNITS{32'h0000_4000}});
        check_eq("basic_cprev1", cprev1, {UNITS{32'h0000_1234}});

        // sign
        load_weights(32'h0000_0000, 32'h0000_0000);
        write_w(0, 32'h8002_0000);
        set_cell(32'h0000_8000, 32'h0);
        run_seq(32'h0000_1000, 32'h8000_1000, 0, 0, 0);
        check_eq("sign_pred", got_pred, 32'h8001_0000);
        check_eq("sign_sat", got_sat, 0);

        // negative zero everywhere
        load_weights(32'h8001_0000, 32'h8000_0000);
        set_cell(32'h8000_0000, 32'h0);
        run_seq(32'h8000_0000, 32'h0000_0001, 0, 0, 0);
        check_eq("negzero_pred", got_pred, 32'h0000_0000);
        check_eq("negzero_sat", got_sat, 0);
        check_eq("negzero_cx0", cx0, 0);

        // saturation
        load_weights(32'h7FFF_0000, 32'h7FFF_0000);
        set_cell(32'h7FFF_0000, 32'h0);
        run_seq(32'h0001_0000, 32'h0001_0000, 0, 0, 0);
        check_eq("sat_pred", got_pred, 32'h7FFF_FFFF);
        check_eq("sat_flag", got_sat, 1);

        // backpressure, then fresh h for the next sequence
        load_weights(32'h0001_0000, 32'h0000_8000);
        set_cell(32'h0000_4000, 32'h0);
        run_seq(32'h0001_0000, 32'h0001_0000, 0, 0, 10);
        check_eq("bp_pred", got_pred, 32'h0001_8000);
        run_seq(32'h0001_0000, 32'h0001_0000, 0, 0, 0);
        check_eq("bp_next_hprev0", hprev0, 0);
        check_eq("bp_next_pred", got_pred, 32'h0001_8000);

        // reset while waiting on the cell
        send_sample(32'h0001_0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstw_x_ready", x_ready, 0);
        check_eq("rstw_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstw_busy_after", busy, 0);
        check_eq("rstw_x_ready_after", x_ready, 1);
        check_eq("rstw_pred_valid", pred_valid, 0);
        check_eq("rstw_h_cleared", cell_h_prev, 0);
        repeat (5) @(negedge clk);
        check_eq("rstw_late_done_idle", busy, 0);
        run_seq(32'h0001_0000, 32'h0001_0000, 0, 0, 0);
        check_eq("rstw_weights_zero", got_pred, 0);

        // weight write while busy is dropped, in IDLE it lands
        load_weights(32'h0001_0000, 32'h0000_0000);
        set_cell(32'h0000_4000, 32'h0);
        run_seq(32'h0001_0000, 32'h0001_0000, 1, 32'h0003_0000, 0);
        check_eq("busy_write_dropped", got_pred, 32'h0001_0000);
        write_w(1, 32'h0003_0000);
        run_seq(32'h0001_0000, 32'h0001_0000, 0, 0, 0);
        check_eq("idle_write_taken", got_pred, 32'h0001_8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
